// File: rtl/ntt_twiddle_multiplier.sv
`timescale 1ns/1ps
// Iterative shift-add multiplier: coefficient x twiddle, full 2*COEFF_W-bit product, index tag carried along.
// Latency: accept edge t -> out_valid high after edge t+COEFF_W (first sampled at edge t+COEFF_W+1); one op in flight.
// Backpressure: in_ready only while idle; the product and tag are held in registers until out_ready.
module ntt_twiddle_multiplier #(
    parameter int COEFF_W = 8,
    parameter int PRIME   = 101,
    parameter int IDX_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COEFF_W-1:0]     in_coeff,
    input  logic [COEFF_W-1:0]     in_twiddle,
    input  logic [IDX_W-1:0]       in_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*COEFF_W-1:0]   out_product,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   range_err,
    input  logic                   clr_err
);

    localparam int PW    = 2 * COEFF_W;
    localparam int CNT_W = (COEFF_W > 1) ? $clog2(COEFF_W) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COEFF_W - 1);
    localparam logic [31:0]      PRIME_U  = 32'(PRIME);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      a_sh_q, a_sh_d;
    logic [COEFF_W-1:0] w_sh_q, w_sh_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [IDX_W-1:0]   oidx_q, oidx_d;
    logic               err_q, err_d;

    logic [PW-1:0]      acc_nxt;
    logic               err_set;
    logic               out_of_range;

    // Operand range check against the modulus; only acted on at accept.
    assign out_of_range = (32'(in_coeff) >= PRIME_U) || (32'(in_twiddle) >= PRIME_U);

    // Next-state: capture in IDLE, one shift-add step per BUSY cycle, hold in DONE until taken.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        w_sh_d  = w_sh_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        oidx_d  = oidx_q;
        err_set = 1'b0;
        acc_nxt = acc_q + (w_sh_q[0] ? a_sh_q : '0);
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = {{COEFF_W{1'b0}}, in_coeff};
                    w_sh_d  = in_twiddle;
                    idx_d   = in_idx;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_set = out_of_range;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Fixed COEFF_W steps, no early exit when the multiplier runs out of ones.
                acc_d  = acc_nxt;
                a_sh_d = a_sh_q << 1;
                w_sh_d = w_sh_q >> 1;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    prod_d  = acc_nxt;
                    oidx_d  = idx_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Sticky error: a new violation beats a simultaneous clear.
        if (err_set) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            w_sh_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            oidx_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            w_sh_q  <= w_sh_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            oidx_q  <= oidx_d;
            err_q   <= err_d;
        end
    end

    // Outputs come straight from registers or a decode of the state register.
    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign out_product = prod_q;
    assign out_idx     = oidx_q;
    assign range_err   = err_q;

endmodule

// File: tb/tb_ntt_twiddle_multiplier.sv
`timescale 1ns/1ps
module tb_ntt_twiddle_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_coeff = '0;
    logic [7:0]  in_twiddle = '0;
    logic [7:0]  in_idx = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_product;
    logic [7:0]  out_idx;
    logic        range_err;
    logic        clr_err = 1'b0;

    ntt_twiddle_multiplier #(.COEFF_W(8), .PRIME(101), .IDX_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_coeff(in_coeff), .in_twiddle(in_twiddle), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_idx(out_idx),
        .range_err(range_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        logic [7:0]  idx;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic exp_err = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one operand pair; caller is just past a rising edge. Returns the accept cycle.
    task automatic send(input logic [7:0] a, input logic [7:0] w, input logic [7:0] idx, output int acc_cyc);
        logic [15:0] p;
        bit          got;
        p = 16'(a) * 16'(w);
        got = 0;
        acc_cyc = -1;
        in_valid = 1'b1; in_coeff = a; in_twiddle = w; in_idx = idx;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                acc_cyc = cyc;
                exp_q.push_back('{p, idx, cyc});
                if (a >= 8'd101 || w >= 8'd101) exp_err = 1'b1;
            end
        end
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: in_ready never rose for idx %0d", idx);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor/scoreboard: compares every presented product against the queue head.
    initial begin
        logic prev_vld;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_vld = 1'b0;
            end else begin
                if (out_valid && !prev_vld) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out: out_valid with product %0d idx %0d, nothing expected", out_product, out_idx);
                    end else begin
                        chk("latency", 32'(cyc - exp_q[0].cyc), 32'd9);
                    end
                end
                if (out_valid) begin
                    chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
                    if (exp_q.size() != 0) begin
                        chk("product", 32'(out_product), 32'(exp_q[0].prod));
                        chk("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                prev_vld = out_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, prev_c;
        logic [7:0] ra, rw;

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_product", 32'(out_product), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_range_err", 32'(range_err), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic product, in range at the modulus boundary minus one
        send(8'd100, 8'd100, 8'd5, c);
        wait_drain();
        chk("range_err_inrange", 32'(range_err), 32'd0);
        @(negedge clk);
        chk("in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Out of range: flag set and held, then cleared
        send(8'd255, 8'd255, 8'd1, c);
        @(negedge clk);
        chk("range_err_set", 32'(range_err), 32'(exp_err));
        wait_drain();
        chk("range_err_held", 32'(range_err), 32'd1);
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0; exp_err = 1'b0;
        @(negedge clk);
        chk("range_err_clr", 32'(range_err), 32'd0);
        @(posedge clk); #1;

        // Set beats a simultaneous clear; coefficient exactly at the modulus
        clr_err = 1'b1;
        send(8'd101, 8'd0, 8'd2, c);
        clr_err = 1'b0;
        @(negedge clk);
        chk("range_err_set_wins", 32'(range_err), 32'd1);
        wait_drain();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0; exp_err = 1'b0;

        // Zero operands still take the full latency
        send(8'd37, 8'd0, 8'd3, c);
        wait_drain();
        send(8'd0, 8'd88, 8'd4, c);
        wait_drain();

        // Backpressure with a stray in_valid during BUSY/DONE
        out_ready = 1'b0;
        send(8'd7, 8'd13, 8'd6, c);
        in_valid = 1'b1; in_coeff = 8'd50; in_twiddle = 8'd2; in_idx = 8'd99;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(negedge clk);
            chk("in_ready_busy", 32'(in_ready), 32'd0);
        end
        repeat (5) begin
            @(negedge clk);
            chk("in_ready_stall", 32'(in_ready), 32'd0);
            chk("valid_stall", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset while BUSY: operation abandoned
        send(8'd9, 8'd9, 8'd7, c);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("abandoned_no_valid", 32'(out_valid), 32'd0);
        end
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_product", 32'(out_product), 32'd0);
        chk("post_rst_idx", 32'(out_idx), 32'd0);
        @(posedge clk); #1;
        send(8'd3, 8'd4, 8'd8, c);
        wait_drain();

        // Back-to-back in-range random pairs: fixed initiation interval
        prev_c = -1;
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 100));
            rw = 8'($urandom_range(0, 100));
            send(ra, rw, 8'(i), c);
            if (prev_c >= 0) chk("initiation_interval", 32'(c - prev_c), 32'd10);
            prev_c = c;
        end
        wait_drain();
        chk("range_err_b2b", 32'(range_err), 32'(exp_err));

        // Full-range random operands: sticky flag tracked by the model
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom_range(0, 255));
            rw = 8'($urandom_range(0, 255));
            send(ra, rw, 8'(100 + i), c);
            wait_drain();
            chk("range_err_rand", 32'(range_err), 32'(exp_err));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
